fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  IF stage plus IF/ID pipeline register, directly upstream of decode. Holds the PC and drives the
//  instruction-memory address. Registers instruction and PC+1 for decode. Takes redirects resolved
//  in decode (taken branch, j/jal, jr). Counters for fetch bandwidth and redirect penalty.
// PARAMETERS
//  PC_WIDTH    10      PC / instruction-memory address width (word addressed)
//  INST_WIDTH  32      instruction width
//  RESET_PC    0       PC value loaded on reset
//  NOP         32'h0   bubble instruction injected into IF/ID (sll $0,$0,0)
//  CNT_WIDTH   32      width of performance counters
// PORTS
//  clk            in   1           clock, all state on rising edge
//  rst            in   1           synchronous, active-high reset
//  imem_data      in   INST_WIDTH  instruction at imem_addr, combinational read same cycle
//  hold           in   1           stall from hazard unit: freeze PC and IF/ID
//  PCSrc          in   1           taken branch resolved in decode
//  adderResult    in   PC_WIDTH    branch target from decode
//  jump           in   1           j/jal in decode
//  jaddress       in   PC_WIDTH    jump target from decode
//  jr             in   1           jr in decode
//  jr_target      in   PC_WIDTH    forwarded rs value [PC_WIDTH-1:0] for jr
//  imem_addr      out  PC_WIDTH    current PC
//  instruction_ID out  INST_WIDTH  IF/ID instruction
//  PCPlus1_ID     out  PC_WIDTH    IF/ID PC+1 (branch adder base and jal link)
//  valid_ID       out  1           1 = IF/ID holds a real fetched instruction, 0 = bubble
//  fetch_count    out  CNT_WIDTH   instructions loaded into IF/ID with valid=1
//  redirect_count out  CNT_WIDTH   accepted redirects (= squashed fetches)
// BEHAVIOUR
//  - Reset (sync, highest priority): PC<=RESET_PC, instruction_ID<=NOP, PCPlus1_ID<=0, valid_ID<=0,
//    both counters<=0. First fetch is from RESET_PC in the cycle after rst deasserts.
//  - imem_addr = PC (combinational). pc_plus1 = PC+1, modulo 2^PC_WIDTH (1023 wraps to 0).
//  - redirect = jr | jump | PCSrc. Target priority: jr -> jr_target, else jump -> jaddress,
//    else PCSrc -> adderResult. Only one is expected at a time; the priority is still enforced.
//  - Per-cycle update, evaluated in this order:
//    1 rst: reset as above.
//    2 hold=1: PC, IF/ID and counters unchanged. A redirect in the same cycle is ignored
//      (decode re-resolves once hold drops).
//    3 redirect=1: PC<=target, instruction_ID<=NOP, valid_ID<=0, PCPlus1_ID<=0.
//      redirect_count++. This squashes the wrong-path instruction, so every taken redirect costs
//      one bubble.
//    4 else: PC<=pc_plus1, instruction_ID<=imem_data, PCPlus1_ID<=pc_plus1, valid_ID<=1,
//      fetch_count++.
//  - Latency: instruction at address A appears on instruction_ID one cycle after imem_addr=A.
//  - A redirect target takes effect the next cycle: imem_addr=target, and target's instruction
//    reaches IF/ID the cycle after that.
//  - Counters wrap silently at 2^CNT_WIDTH. Neither counter advances under hold.
//  - Reset mid-stall or mid-redirect: reset wins. No pending redirect state survives.
//  - No X propagation: outputs are fully defined from the first cycle after reset.
// TESTING
//  1 Reset then run 4 cycles, imem[k]=k+100.
//    -> imem_addr 0,1,2,3; instruction_ID 100,101,102 from cycle 2; PCPlus1_ID 1,2,3;
//       fetch_count=3.
//  2 hold=1 for 3 cycles at PC=5.
//    -> imem_addr stays 5; IF/ID and fetch_count frozen; after release, PC=6 and IF/ID=imem[5].
//  3 PCSrc=1, adderResult=40 at PC=8.
//    -> next cycle imem_addr=40, valid_ID=0, instruction_ID=NOP, redirect_count=1;
//       following cycle instruction_ID=imem[40], PCPlus1_ID=41.
//  4 jr=1 (jr_target=12) with jump=1 (jaddress=30) and PCSrc=1 in the same cycle.
//    -> imem_addr=12 next cycle.
//  5 hold=1 with jump=1, jaddress=20.
//    -> PC unchanged, redirect_count unchanged; then hold=0 with jump=1 -> imem_addr=20.
//  6 Wrap: redirect to 1023, then free-run -> imem_addr 1023 then 0, PCPlus1_ID=0.
//    Also assert rst during hold -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - instruction-memory and decode-side signal bundle for the fetch stage
interface fetch_stage_if #(
    parameter int PC_WIDTH   = 10,
    parameter int INST_WIDTH = 32,
    parameter int CNT_WIDTH  = 32
);
    logic [PC_WIDTH-1:0]   imem_addr;
    logic [INST_WIDTH-1:0] imem_data;
    logic                  hold;
    logic                  PCSrc;
    logic [PC_WIDTH-1:0]   adderResult;
    logic                  jump;
    logic [PC_WIDTH-1:0]   jaddress;
    logic                  jr;
    logic [PC_WIDTH-1:0]   jr_target;
    logic [INST_WIDTH-1:0] instruction_ID;
    logic [PC_WIDTH-1:0]   PCPlus1_ID;
    logic                  valid_ID;
    logic [CNT_WIDTH-1:0]  fetch_count;
    logic [CNT_WIDTH-1:0]  redirect_count;

    modport master (
        input  imem_data, hold, PCSrc, adderResult, jump, jaddress, jr, jr_target,
        output imem_addr, instruction_ID, PCPlus1_ID, valid_ID, fetch_count, redirect_count
    );

    modport slave (
        output imem_data, hold, PCSrc, adderResult, jump, jaddress, jr, jr_target,
        input  imem_addr, instruction_ID, PCPlus1_ID, valid_ID, fetch_count, redirect_count
    );
endinterface

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - IF stage with IF/ID register, decode redirects and perf counters
module fetch_stage #(
    parameter int                    PC_WIDTH   = 10,
    parameter int                    INST_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0]   RESET_PC   = '0,
    parameter logic [INST_WIDTH-1:0] NOP        = '0,
    parameter int                    CNT_WIDTH  = 32
) (
    input  logic          clk,
    input  logic          rst,
    fetch_stage_if.master bus
);
    logic [PC_WIDTH-1:0] pc;
    logic [PC_WIDTH-1:0] pc_plus1;
    logic [PC_WIDTH-1:0] target;
    logic                redirect;

    assign bus.imem_addr = pc;
    assign pc_plus1      = pc + PC_WIDTH'(1);
    assign redirect      = bus.jr | bus.jump | bus.PCSrc;

    // jr outranks jump, which outranks a taken branch, should decode ever raise several at once
    always_comb begin
        target = bus.adderResult;
        if (bus.jr) begin
            target = bus.jr_target;
        end else if (bus.jump) begin
            target = bus.jaddress;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc                 <= RESET_PC;
            bus.instruction_ID <= NOP;
            bus.PCPlus1_ID     <= '0;
            bus.valid_ID       <= 1'b0;
            bus.fetch_count    <= '0;
            bus.redirect_count <= '0;
        end else if (bus.hold) begin
            // a redirect under hold is dropped; decode presents it again after the stall
            pc <= pc;
        end else if (redirect) begin
            pc                 <= target;
            bus.instruction_ID <= NOP;
            bus.PCPlus1_ID     <= '0;
            bus.valid_ID       <= 1'b0;
            bus.redirect_count <= bus.redirect_count + CNT_WIDTH'(1);
        end else begin
            pc                 <= pc_plus1;
            bus.instruction_ID <= bus.imem_data;
            bus.PCPlus1_ID     <= pc_plus1;
            bus.valid_ID       <= 1'b1;
            bus.fetch_count    <= bus.fetch_count + CNT_WIDTH'(1);
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed and randomized bench for fetch_stage against a behavioural model
module tb_fetch_stage;
    localparam int PW = 10;
    localparam int IW = 32;
    localparam int CW = 32;
    localparam int DEPTH = 1 << PW;

    logic clk = 1'b0;
    logic rst;

    fetch_stage_if #(.PC_WIDTH(PW), .INST_WIDTH(IW), .CNT_WIDTH(CW)) bus();

    fetch_stage #(.PC_WIDTH(PW), .INST_WIDTH(IW), .RESET_PC('0), .NOP('0), .CNT_WIDTH(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [IW-1:0] imem [0:DEPTH-1];
    assign bus.imem_data = imem[bus.imem_addr];

    int checks   = 0;
    int failures = 0;

    int          m_pc;
    int unsigned m_inst;
    int          m_pp1;
    int          m_valid;
    int unsigned m_fetch;
    int unsigned m_redir;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic model_edge();
        if (rst) begin
            m_pc = 0; m_inst = 0; m_pp1 = 0; m_valid = 0; m_fetch = 0; m_redir = 0;
        end else if (bus.hold) begin
            m_pc = m_pc;
        end else if (bus.jr || bus.jump || bus.PCSrc) begin
            if (bus.jr)        m_pc = int'(bus.jr_target);
            else if (bus.jump) m_pc = int'(bus.jaddress);
            else               m_pc = int'(bus.adderResult);
            m_inst = 0; m_pp1 = 0; m_valid = 0;
            m_redir = m_redir + 1;
        end else begin
            m_inst  = imem[m_pc];
            m_pp1   = (m_pc + 1) % DEPTH;
            m_pc    = (m_pc + 1) % DEPTH;
            m_valid = 1;
            m_fetch = m_fetch + 1;
        end
    endtask

    task automatic compare_all();
        chk("imem_addr",      64'(bus.imem_addr),      64'(m_pc));
        chk("instruction_ID", 64'(bus.instruction_ID), 64'(m_inst));
        chk("PCPlus1_ID",     64'(bus.PCPlus1_ID),     64'(m_pp1));
        chk("valid_ID",       64'(bus.valid_ID),       64'(m_valid));
        chk("fetch_count",    64'(bus.fetch_count),    64'(m_fetch));
        chk("redirect_count", 64'(bus.redirect_count), 64'(m_redir));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic clear_inputs();
        bus.hold = 1'b0; bus.PCSrc = 1'b0; bus.jump = 1'b0; bus.jr = 1'b0;
        bus.adderResult = '0; bus.jaddress = '0; bus.jr_target = '0;
    endtask

    initial begin
        for (int k = 0; k < DEPTH; k++) imem[k] = IW'(k + 100);
        m_pc = 0; m_inst = 0; m_pp1 = 0; m_valid = 0; m_fetch = 0; m_redir = 0;
        clear_inputs();
        rst = 1'b1;
        cycle();
        cycle();
        chk("reset_addr", 64'(bus.imem_addr), 64'd0);
        chk("reset_valid", 64'(bus.valid_ID), 64'd0);
        rst = 1'b0;

        // basic streaming from RESET_PC
        for (int i = 1; i <= 3; i++) begin
            cycle();
            chk("stream_addr", 64'(bus.imem_addr), 64'(i));
            chk("stream_inst", 64'(bus.instruction_ID), 64'(99 + i));
            chk("stream_pp1",  64'(bus.PCPlus1_ID), 64'(i));
        end
        chk("stream_fetch_count", 64'(bus.fetch_count), 64'd3);

        // stall at PC=5
        cycle(); cycle();
        chk("pre_hold_addr", 64'(bus.imem_addr), 64'd5);
        bus.hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("hold_addr", 64'(bus.imem_addr), 64'd5);
            chk("hold_inst", 64'(bus.instruction_ID), 64'd104);
            chk("hold_fetch", 64'(bus.fetch_count), 64'd5);
        end
        bus.hold = 1'b0;
        cycle();
        chk("release_addr", 64'(bus.imem_addr), 64'd6);
        chk("release_inst", 64'(bus.instruction_ID), 64'd105);

        // taken branch at PC=8
        cycle(); cycle();
        chk("pre_branch_addr", 64'(bus.imem_addr), 64'd8);
        bus.PCSrc = 1'b1; bus.adderResult = 10'd40;
        cycle();
        chk("branch_addr", 64'(bus.imem_addr), 64'd40);
        chk("branch_valid", 64'(bus.valid_ID), 64'd0);
        chk("branch_nop", 64'(bus.instruction_ID), 64'd0);
        chk("branch_redir", 64'(bus.redirect_count), 64'd1);
        clear_inputs();
        cycle();
        chk("branch_target_inst", 64'(bus.instruction_ID), 64'd140);
        chk("branch_target_pp1", 64'(bus.PCPlus1_ID), 64'd41);

        // all three redirects at once: jr wins
        bus.jr = 1'b1; bus.jr_target = 10'd12;
        bus.jump = 1'b1; bus.jaddress = 10'd30;
        bus.PCSrc = 1'b1; bus.adderResult = 10'd50;
        cycle();
        chk("prio_addr", 64'(bus.imem_addr), 64'd12);
        clear_inputs();

        // redirect ignored under hold, taken once hold drops
        bus.hold = 1'b1; bus.jump = 1'b1; bus.jaddress = 10'd20;
        cycle();
        chk("hold_jump_addr", 64'(bus.imem_addr), 64'd12);
        chk("hold_jump_redir", 64'(bus.redirect_count), 64'd2);
        bus.hold = 1'b0;
        cycle();
        chk("jump_addr", 64'(bus.imem_addr), 64'd20);
        clear_inputs();

        // PC wrap
        bus.PCSrc = 1'b1; bus.adderResult = 10'd1023;
        cycle();
        chk("wrap_top", 64'(bus.imem_addr), 64'd1023);
        clear_inputs();
        cycle();
        chk("wrap_addr", 64'(bus.imem_addr), 64'd0);
        chk("wrap_pp1", 64'(bus.PCPlus1_ID), 64'd0);
        chk("wrap_inst", 64'(bus.instruction_ID), 64'd1123);

        // reset during hold with a redirect pending
        bus.hold = 1'b1; bus.jump = 1'b1; bus.jaddress = 10'd77;
        cycle();
        rst = 1'b1;
        cycle();
        chk("rst_hold_addr", 64'(bus.imem_addr), 64'd0);
        chk("rst_hold_fetch", 64'(bus.fetch_count), 64'd0);
        chk("rst_hold_redir", 64'(bus.redirect_count), 64'd0);
        rst = 1'b0;
        clear_inputs();

        // randomized traffic against the model
        for (int k = 0; k < DEPTH; k++) imem[k] = $urandom;
        for (int n = 0; n < 600; n++) begin
            clear_inputs();
            rst = ($urandom_range(0, 99) < 2);
            bus.hold = ($urandom_range(0, 99) < 20);
            if ($urandom_range(0, 99) < 25) begin
                bus.PCSrc = $urandom_range(0, 1) == 1;
                bus.jump  = $urandom_range(0, 1) == 1;
                bus.jr    = $urandom_range(0, 1) == 1;
            end
            bus.adderResult = PW'($urandom_range(0, DEPTH - 1));
            bus.jaddress    = PW'($urandom_range(0, DEPTH - 1));
            bus.jr_target   = PW'($urandom_range(0, DEPTH - 1));
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
